// File: rtl/pwm_demod.sv
// rtl/pwm_demod.sv - PWM frame decoder: measures period and high time between rising edges, flags stalled input.
module pwm_demod #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic             sample_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             overflow,
    output logic             dc_level
);

    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, prev;
    logic             rise;
    logic [CNT_W-1:0] per_acc, hi_acc;
    logic [CNT_W-1:0] per_nxt, hi_nxt;
    logic             emit, emit_ov;

    // Synchronizer keeps running while disabled so rise is never stale on re-enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= pwm_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

    always_comb begin
        state_nxt = state;
        per_nxt   = per_acc;
        hi_nxt    = hi_acc;
        emit      = 1'b0;
        emit_ov   = 1'b0;
        if (!ena) begin
            state_nxt = IDLE;
            per_nxt   = '0;
            hi_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_nxt = MEASURE;
                        per_nxt   = ONE;
                        hi_nxt    = ONE;
                    end
                end
                MEASURE: begin
                    // A rise on the saturating cycle still closes a normal frame.
                    if (rise) begin
                        emit    = 1'b1;
                        per_nxt = ONE;
                        hi_nxt  = ONE;
                    end else if (per_acc == MAX) begin
                        emit      = 1'b1;
                        emit_ov   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        per_nxt = per_acc + ONE;
                        if (s2 && (hi_acc != MAX))
                            hi_nxt = hi_acc + ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            per_acc      <= '0;
            hi_acc       <= '0;
            sample_valid <= 1'b0;
            period_cnt   <= '0;
            high_cnt     <= '0;
            overflow     <= 1'b0;
            dc_level     <= 1'b0;
        end else begin
            state        <= state_nxt;
            per_acc      <= per_nxt;
            hi_acc       <= hi_nxt;
            sample_valid <= emit;
            if (emit) begin
                period_cnt <= per_acc;
                high_cnt   <= hi_acc;
                overflow   <= emit_ov;
                dc_level   <= emit_ov & s2;
            end
        end
    end

endmodule
